// File: rtl/blink_sequencer_pkg.sv
// Shared definitions for the LED blink sequencer: FSM states, pattern-entry
// field positions and the duration clamp helper.
package blink_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Pattern entry layout: [31:0] duration, [32] LED level, [33] last flag,
  // anything above is reserved and ignored.
  localparam int DUR_MSB  = 31;
  localparam int LVL_BIT  = 32;
  localparam int LAST_BIT = 33;

  // A zero duration still shows the entry for one cycle.
  function automatic logic [31:0] eff_dur(input logic [31:0] dur);
    return (dur == 32'd0) ? 32'd1 : dur;
  endfunction

endpackage

// File: rtl/blink_pattern_ram.sv
// Pattern table: one write port, one registered read port, no reset.
// A write to the address being read in the same cycle is forwarded so that a
// freshly written entry 0 is seen by a start issued in that same cycle.
module blink_pattern_ram #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 40,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Table write; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read with write-first forwarding on an address match.
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// LED blink sequencer: steps through a table of {level, duration, last}
// entries, driving a registered LED output, optionally looping forever.
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int DEPTH = 11,
  parameter int WIDTH = 40,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx,
  output logic             cfg_err
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(DEPTH);

  state_t           state, state_nx;
  logic [AW-1:0]    idx_nx;
  logic [31:0]      cnt, cnt_nx;
  logic             led_nx;
  logic             last_flag, last_nx;
  logic             wr_ok;
  logic             end_of_entry;
  logic             final_entry;
  logic [WIDTH-1:0] entry;
  logic             unused_rsvd;

  // Reserved entry bits carry no meaning.
  assign unused_rsvd = ^entry[WIDTH-1:LAST_BIT+1];

  // Table is writable only while idle and only inside its depth; reset blocks writes.
  assign wr_ok = cfg_we && !rst && (state == IDLE) && ({1'b0, cfg_addr} < DEPTH_LIM);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign end_of_entry = (cnt <= 32'd1);
  assign final_entry  = last_flag || (cur_idx == LAST_IDX);

  // The read address follows the next index so the entry is ready during LOAD.
  blink_pattern_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx_nx),
    .rdata (entry)
  );

  // State, LED, index and duration registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      led       <= 1'b0;
      cur_idx   <= '0;
      cnt       <= '0;
      last_flag <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      led       <= led_nx;
      cur_idx   <= idx_nx;
      cnt       <= cnt_nx;
      last_flag <= last_nx;
      cfg_err   <= cfg_we && !wr_ok;
    end
  end

  // Next-state logic: load entry, run its duration, decide next entry or finish.
  always_comb begin
    state_nx = state;
    idx_nx   = cur_idx;
    cnt_nx   = cnt;
    led_nx   = led;
    last_nx  = last_flag;
    case (state)
      IDLE: begin
        led_nx = 1'b0;
        if (start && !stop) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nx = IDLE;
          led_nx   = 1'b0;
        end else begin
          state_nx = RUN;
          led_nx   = entry[LVL_BIT];
          cnt_nx   = eff_dur(entry[DUR_MSB:0]);
          last_nx  = entry[LAST_BIT];
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
          led_nx   = 1'b0;
        end else if (end_of_entry) begin
          if (final_entry) begin
            if (loop_en) begin
              state_nx = LOAD;
              idx_nx   = '0;
            end else begin
              state_nx = DONE;
              led_nx   = 1'b0;
            end
          end else begin
            state_nx = LOAD;
            idx_nx   = cur_idx + AW'(1);
          end
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        led_nx   = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        led_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 11, meaning number of pattern-table entries.
REQ-002 SHALL have parameter WIDTH, default 40, meaning pattern-table word width in bits.
REQ-003 SHALL have parameter AW, default 4, meaning table address width (2**AW >= DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin sequence at entry 0.
REQ-007 SHALL have port stop  input  1  single-cycle abort request.
REQ-008 SHALL have port loop_en  input  1  restart at entry 0 after final entry instead of finishing.
REQ-009 SHALL have port cfg_we  input  1  table write strobe.
REQ-010 SHALL have port cfg_addr  input  AW  table write address.
REQ-011 SHALL have port cfg_wdata  input  WIDTH  table write data.
REQ-012 SHALL have port led  output  1  registered LED drive.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.
REQ-015 SHALL have port cur_idx  output  AW  index of entry currently loaded or running.
REQ-016 SHALL have port cfg_err  output  1  one-cycle pulse, cycle after a rejected write.

Function
REQ-017 Entry format SHALL be: [31:0] duration in cycles (0 treated as 1); [32] LED level; [33] last-entry flag; [39:34] reserved, ignored.
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, DONE.
REQ-019 IDLE + start (stop low) SHALL go to LOAD with cur_idx=0 next cycle; start ignored outside IDLE.
REQ-020 LOAD SHALL take exactly one cycle (registered table read), then RUN; led holds previous value during LOAD.
REQ-021 On entering RUN, led SHALL equal entry bit 32 and remain so for max(duration,1) cycles.
REQ-022 After final RUN cycle of an entry: if bit 33 set or cur_idx==DEPTH-1, go to LOAD idx 0 when loop_en=1, else DONE; otherwise LOAD cur_idx+1.
REQ-023 loop_en SHALL be sampled only at the end-of-entry decision point.
REQ-024 DONE SHALL last one cycle with done=1, led=0, then IDLE.
REQ-025 stop in LOAD, RUN or DONE SHALL force IDLE next cycle, led=0, no done pulse; stop with start in IDLE: stop wins, stays IDLE.
REQ-026 Duration counter SHALL be 32 bits and never wrap; 0xFFFFFFFF runs 2**32-1 cycles.
REQ-027 Writes SHALL be accepted only when busy=0 and cfg_addr<DEPTH; otherwise data dropped, cfg_err pulses.
REQ-028 Write and start in same IDLE cycle: write SHALL commit; LOAD of entry 0 sees new data.
REQ-029 Latency start->first led update SHALL be 2 cycles.

Reset
REQ-030 rst SHALL force IDLE, led=0, busy=0, done=0, cfg_err=0, cur_idx=0, counter=0 next edge.
REQ-031 rst SHALL take priority over start, stop and cfg_we, including mid-RUN.
REQ-032 Table contents SHALL NOT be reset; software writes table before start.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and entry field bit positions (DUR_MSB=31, LVL_BIT=32, LAST_BIT=33).
REQ-034 Table storage SHALL be sub-module blink_pattern_ram (1 write port, 1 registered read port, DEPTH x WIDTH, no reset).

Verification
REQ-035 Write e0={lvl=1,dur=3}, e1={lvl=0,dur=2,last=1}; start at T -> led 1 at T+2..T+4, LOAD T+5, led 0 T+6..T+7, done=1 at T+8, busy=0 at T+9.
REQ-036 Same table, loop_en=1 -> pattern repeats with period 7 cycles, done never asserts; stop mid-RUN -> led=0, busy=0 next cycle, no done.
REQ-037 e0={dur=0,lvl=1,last=1}, loop_en=0 -> led=1 for exactly 1 cycle, then done.
REQ-038 All 11 entries dur=1, no last flag -> terminates after cur_idx=10, done once; cur_idx sequence 0..10.
REQ-039 cfg_we while busy, or cfg_addr=11 -> cfg_err pulse, readback via run shows table unchanged.
REQ-040 rst asserted mid-RUN with start also high -> IDLE, all outputs 0 next cycle; start one cycle after rst release begins normally.
